// File: rtl/app_ps_arb_if.sv
// AXI-Stream channel bundle shared by the two ingress ports and the merged egress
// port of the application arbiter.
interface app_ps_arb_if #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_ID_WIDTH   = 8,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int AXIS_USER_WIDTH = 128
);
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic [AXIS_KEEP_WIDTH-1:0] tkeep;
    logic                       tvalid;
    logic                       tready;
    logic                       tlast;
    logic [AXIS_ID_WIDTH-1:0]   tid;
    logic [AXIS_DEST_WIDTH-1:0] tdest;
    logic [AXIS_USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/app_ps_arb.sv
// Frame-aware weighted round-robin merge of the bypass stream (port 0) and the
// PS PKTOUT stream (port 1) onto one registered egress stream.
module app_ps_arb #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_ID_WIDTH   = 8,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int AXIS_USER_WIDTH = 128,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    app_ps_arb_if.slave             s0_axis,
    app_ps_arb_if.slave             s1_axis,
    app_ps_arb_if.master            m_axis,
    input  logic                    cfg_enable,
    input  logic [WEIGHT_WIDTH-1:0] cfg_weight0,
    input  logic [WEIGHT_WIDTH-1:0] cfg_weight1,
    output logic [STAT_WIDTH-1:0]   stat_frames0,
    output logic [STAT_WIDTH-1:0]   stat_frames1,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    localparam logic [WEIGHT_WIDTH-1:0] ONE_W = WEIGHT_WIDTH'(1);

    state_t                    state_q, state_d;
    logic                      last_q, last_d;
    logic [WEIGHT_WIDTH-1:0]   credit_q, credit_d;
    logic [WEIGHT_WIDTH-1:0]   w0, w1;
    logic                      grant_port, do_grant;
    logic                      out_ready, acc0, acc1, acc, acc_last, arb_point;

    logic [AXIS_DATA_WIDTH-1:0] sel_tdata, m_tdata_q;
    logic [AXIS_KEEP_WIDTH-1:0] sel_tkeep, m_tkeep_q;
    logic                       sel_tlast, m_tlast_q;
    logic [AXIS_ID_WIDTH-1:0]   sel_tid, m_tid_q;
    logic [AXIS_DEST_WIDTH-1:0] sel_tdest, m_tdest_q;
    logic [AXIS_USER_WIDTH-1:0] sel_tuser, m_tuser_q;
    logic                       m_tvalid_q;

    // A zero weight still earns one frame per turn.
    assign w0 = (cfg_weight0 == '0) ? ONE_W : cfg_weight0;
    assign w1 = (cfg_weight1 == '0) ? ONE_W : cfg_weight1;

    assign out_ready      = !m_tvalid_q || m_axis.tready;
    assign s0_axis.tready = (state_q == GNT0) && out_ready;
    assign s1_axis.tready = (state_q == GNT1) && out_ready;
    assign acc0           = s0_axis.tvalid && s0_axis.tready;
    assign acc1           = s1_axis.tvalid && s1_axis.tready;
    assign acc            = acc0 || acc1;
    assign acc_last       = (acc0 && s0_axis.tlast) || (acc1 && s1_axis.tlast);
    assign arb_point      = (state_q == IDLE) || acc_last;
    assign busy           = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        last_d     = last_q;
        credit_d   = credit_q;
        grant_port = last_q;
        do_grant   = 1'b0;
        if (arb_point) begin
            state_d = IDLE;
            if (cfg_enable && s0_axis.tvalid && s1_axis.tvalid) begin
                do_grant = 1'b1;
                if (credit_q != '0) begin
                    grant_port = last_q;
                    credit_d   = credit_q - ONE_W;
                end else begin
                    grant_port = !last_q;
                    credit_d   = (grant_port ? w1 : w0) - ONE_W;
                end
            end else if (cfg_enable && (s0_axis.tvalid || s1_axis.tvalid)) begin
                do_grant   = 1'b1;
                grant_port = s1_axis.tvalid;
                // A lone requester that already held the last turn keeps spending its credit.
                if (grant_port != last_q) begin
                    credit_d = (grant_port ? w1 : w0) - ONE_W;
                end else if (credit_q != '0) begin
                    credit_d = credit_q - ONE_W;
                end
            end
            if (do_grant) begin
                state_d = grant_port ? GNT1 : GNT0;
                last_d  = grant_port;
            end
        end
    end

    always_comb begin
        sel_tdata = s0_axis.tdata;
        sel_tkeep = s0_axis.tkeep;
        sel_tlast = s0_axis.tlast;
        sel_tid   = s0_axis.tid;
        sel_tdest = s0_axis.tdest;
        sel_tuser = s0_axis.tuser;
        if (state_q == GNT1) begin
            sel_tdata = s1_axis.tdata;
            sel_tkeep = s1_axis.tkeep;
            sel_tlast = s1_axis.tlast;
            sel_tid   = s1_axis.tid;
            sel_tdest = s1_axis.tdest;
            sel_tuser = s1_axis.tuser;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            credit_q <= credit_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
            m_tdest_q  <= '0;
            m_tuser_q  <= '0;
        end else if (acc) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= sel_tdata;
            m_tkeep_q  <= sel_tkeep;
            m_tlast_q  <= sel_tlast;
            m_tid_q    <= sel_tid;
            m_tdest_q  <= sel_tdest;
            m_tuser_q  <= sel_tuser;
        end else if (m_axis.tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames0 <= '0;
            stat_frames1 <= '0;
        end else begin
            if (acc0 && s0_axis.tlast) stat_frames0 <= stat_frames0 + 1'b1;
            if (acc1 && s1_axis.tlast) stat_frames1 <= stat_frames1 + 1'b1;
        end
    end

    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tkeep  = m_tkeep_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tid    = m_tid_q;
    assign m_axis.tdest  = m_tdest_q;
    assign m_axis.tuser  = m_tuser_q;
endmodule

// File: doc/app_ps_arb.md
Name: app_ps_arb

Overview:
- Frame-aware weighted round-robin arbiter that merges two AXI-Stream sources onto the single application egress stream.
- Port 0 is the bypass/fast-path stream; port 1 is the PS PKTOUT stream from the width/clock adapter.
- The grant is held for a whole frame, so frames never interleave; per-port weights set the frame share while both ports are busy.
- One registered output stage; per-port frame counters for software statistics.

Parameters:
AXIS_DATA_WIDTH, 512, tdata width
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
AXIS_ID_WIDTH, 8, tid width
AXIS_DEST_WIDTH, 4, tdest width
AXIS_USER_WIDTH, 128, tuser width
WEIGHT_WIDTH, 8, width of per-port weight (frames per turn)
STAT_WIDTH, 32, width of per-port frame counters

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
s0_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  per params  port 0 (bypass) slave
s1_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  per params  port 1 (PS PKTOUT) slave
m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  per params  merged master
cfg_enable  in  1  1 = new grants allowed
cfg_weight0  in  WEIGHT_WIDTH  consecutive frames for port 0 per turn (0 treated as 1)
cfg_weight1  in  WEIGHT_WIDTH  same for port 1
stat_frames0  out  STAT_WIDTH  frames forwarded from port 0
stat_frames1  out  STAT_WIDTH  frames forwarded from port 1
busy  out  1  high while a frame grant is held

Behaviour:
Reset values (rst_n low, asynchronous):
- State IDLE; last_port = 1 (port 0 wins the first contention); credit = 0.
- m_axis_tvalid = 0; m_axis data fields = 0.
- s0/s1 tready = 0; stat counters = 0; busy = 0.

State machine (IDLE, GNT0, GNT1):
- Arbitration point: in IDLE, or on the cycle the granted port's tlast beat is accepted.
- Arbitration uses cfg_enable and the s0/s1 tvalid values of that cycle; the result is registered as the next state.
- Back-to-back frames therefore pass with zero bubble cycles.
- From IDLE, the first beat of a frame is accepted the cycle after its tvalid is first seen.

Grant decision (all comparisons use w = max(cfg_weightN, 1)):
- cfg_enable = 0 -> IDLE; no new grant.
- Only one port valid -> grant it. Credit is reloaded to w_new-1 when the port differs from last_port, else decremented with a floor of 0.
- Both ports valid and credit > 0 -> grant last_port; credit-1.
- Both ports valid and credit = 0 -> grant the other port; credit = w_other-1.
- Neither valid -> IDLE. last_port and credit are kept.
- On every grant, last_port = granted port.

Datapath:
- Granted port tready = !m_axis_tvalid || m_axis_tready. The non-granted port tready = 0.
- On an accepted beat, all fields are registered into the output stage next cycle. Latency is 1 cycle, with full throughput.
- m_axis_tvalid clears on m_axis_tready when no new beat is accepted.
- Output fields are held stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- tid/tdest/tuser pass through unchanged; the block adds no port tagging.

Enable:
- cfg_enable dropping mid-frame does not cut the current frame. It completes, then the block goes to IDLE.

Stats and busy:
- stat_framesN increments on each accepted tlast beat from port N and wraps from 2^STAT_WIDTH-1 to 0.
- busy = (state != IDLE).

Weights:
- Weights are sampled only at arbitration points. A change mid-frame takes effect at the next arbitration.

Source misbehaviour:
- A granted source that drops tvalid mid-frame keeps the grant indefinitely. There is no timeout.

Reset mid-frame:
- An asynchronous reset drops the partial frame immediately; downstream sees a truncated frame.
- After rst_n rises, arbitration restarts from IDLE.

Test Plan:
1. Only s0 valid, 3 frames of 4 beats, m_tready = 1 -> 12 beats out in order, first beat 2 cycles after first s0 tvalid, no gaps; stat_frames0 = 3, stat_frames1 = 0.
2. Both ports continuously valid, weights 1/1, 1-beat frames -> output alternates 0,1,0,1…, starting with port 0; no idle cycles between frames.
3. Both ports continuously valid, weight0 = 3, weight1 = 1 -> frame source pattern 0,0,0,1,0,0,0,1; weight0 = 0 behaves exactly as weight0 = 1.
4. Random m_tready (50%) with an 8-beat port-1 frame while port 0 is also valid -> no beat loss or duplication; fields stable while stalled; no port-0 beat appears before the port-1 tlast.
5. cfg_enable cleared at beat 2 of a 6-beat frame -> all 6 beats complete, busy falls, no further grants; re-enable -> the pending port is granted next.
6. rst_n pulsed low at beat 3 of a 5-beat frame -> m_tvalid = 0 and tready = 0 immediately, counters = 0; after release, port 0 wins the first contention.
